// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32IM core: instruction fetch, decode and datapath sequencing.
// Define RV32M_EN to enable the multiply/divide path and its timeout counter.
module multicycle_controller #(
  parameter int unsigned MULDIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] ir,
  output logic [2:0]  immSel,
  output logic        aluSrcA,
  output logic        aluSrcB,
  input  logic        branchTaken,
  output logic        pcWrite,
  output logic [1:0]  pcSel,
  output logic        dmemReq,
  output logic        dmemWe,
  input  logic        dmemAck,
  output logic        mulDivStart,
  input  logic        mulDivDone,
  output logic        regWrite,
  output logic [1:0]  wbSel,
  output logic        trap
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam logic [2:0] ImmI    = 3'b000;
  localparam logic [2:0] ImmS    = 3'b001;
  localparam logic [2:0] ImmB    = 3'b010;
  localparam logic [2:0] ImmJ    = 3'b011;
  localparam logic [2:0] ImmU    = 3'b100;
  localparam logic [2:0] ImmNone = 3'b101;

  localparam logic [1:0] PcPlus4 = 2'b00;
  localparam logic [1:0] PcImm   = 2'b01;
  localparam logic [1:0] PcAlu   = 2'b10;

  localparam logic [1:0] WbAlu  = 2'b00;
  localparam logic [1:0] WbLoad = 2'b01;
  localparam logic [1:0] WbPc4  = 2'b10;
  localparam logic [1:0] WbImm  = 2'b11;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMulDiv, StMem, StWb, StTrap
  } state_e;

  typedef enum logic [3:0] {
    ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad, ClsStore, ClsOpImm, ClsOp,
    ClsMulDiv, ClsIllegal
  } cls_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  cls_e        cls;
  logic [2:0]  imm_fmt;
  logic        active;

  // Instruction class and immediate format, derived purely from the instruction register.
  always_comb begin
    cls     = ClsIllegal;
    imm_fmt = ImmNone;
    unique case (ir_q[6:0])
      OpLui:    begin cls = ClsLui;    imm_fmt = ImmU; end
      OpAuipc:  begin cls = ClsAuipc;  imm_fmt = ImmU; end
      OpJal:    begin cls = ClsJal;    imm_fmt = ImmJ; end
      OpJalr:   begin cls = ClsJalr;   imm_fmt = ImmI; end
      OpBranch: begin cls = ClsBranch; imm_fmt = ImmB; end
      OpLoad:   begin cls = ClsLoad;   imm_fmt = ImmI; end
      OpStore:  begin cls = ClsStore;  imm_fmt = ImmS; end
      OpOpImm:  begin cls = ClsOpImm;  imm_fmt = ImmI; end
      OpOp: begin
        if (ir_q[31:25] == 7'b0000001) begin
`ifdef RV32M_EN
          cls = ClsMulDiv;
`else
          cls = ClsIllegal;
`endif
        end else begin
          cls = ClsOp;
        end
      end
      default: ;
    endcase
  end

`ifdef RV32M_EN
  localparam int unsigned CntW = $clog2(MULDIV_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MULDIV_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;

  // Counter is held at zero outside MULDIV, so it is cleared on every entry.
  assign cnt_d   = (state_q == StMulDiv) ? cnt_q + CntW'(1) : '0;
  assign timeout = (cnt_q == CntLast);
`else
  logic unused_muldiv;
  assign unused_muldiv = mulDivDone ^ (MULDIV_TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (imemAck) state_d = StDecode;
      StDecode: state_d = (cls == ClsIllegal) ? StTrap : StExec;
      StExec: begin
        unique case (cls)
          ClsBranch:         state_d = StFetch;
          ClsLoad, ClsStore: state_d = StMem;
          ClsMulDiv:         state_d = StMulDiv;
          default:           state_d = StWb;
        endcase
      end
      StMulDiv: begin
`ifdef RV32M_EN
        if (mulDivDone) begin
          state_d = StWb;
        end else if (timeout) begin
          state_d = StTrap;
        end
`else
        state_d = StTrap;
`endif
      end
      StMem:    if (dmemAck) state_d = (cls == ClsStore) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      ir_q    <= 32'h0000_0013;
`ifdef RV32M_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && imemAck) begin
        ir_q <= imemData;
      end
`ifdef RV32M_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Decoded selects are only meaningful between DECODE and the last state of the instruction.
  assign active  = (state_q != StFetch) && (state_q != StTrap);
  assign immSel  = active ? imm_fmt : ImmNone;
  assign aluSrcA = active && (cls inside {ClsAuipc, ClsJal, ClsBranch});
  assign aluSrcB = active && !(cls inside {ClsOp, ClsMulDiv, ClsIllegal});

  always_comb begin
    imemReq     = 1'b0;
    pcWrite     = 1'b0;
    pcSel       = PcPlus4;
    dmemReq     = 1'b0;
    dmemWe      = 1'b0;
    mulDivStart = 1'b0;
    regWrite    = 1'b0;
    wbSel       = WbAlu;
    unique case (state_q)
      // Reset lands in FETCH, so the request is gated to drop while rst is held.
      StFetch: imemReq = !rst;
      StExec: begin
        if (cls == ClsBranch) begin
          pcWrite = 1'b1;
          pcSel   = branchTaken ? PcImm : PcPlus4;
        end
`ifdef RV32M_EN
        mulDivStart = (cls == ClsMulDiv);
`endif
      end
      StMem: begin
        dmemReq = 1'b1;
        dmemWe  = (cls == ClsStore);
        if (dmemAck && cls == ClsStore) begin
          pcWrite = 1'b1;
          pcSel   = PcPlus4;
        end
      end
      StWb: begin
        regWrite = (ir_q[11:7] != 5'd0);
        pcWrite  = 1'b1;
        unique case (cls)
          ClsLoad:         wbSel = WbLoad;
          ClsJal, ClsJalr: wbSel = WbPc4;
          ClsLui:          wbSel = WbImm;
          default:         wbSel = WbAlu;
        endcase
        unique case (cls)
          ClsJal:  pcSel = PcImm;
          ClsJalr: pcSel = PcAlu;
          default: pcSel = PcPlus4;
        endcase
      end
      default: ;
    endcase
  end

  assign ir   = ir_q;
  assign trap = (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller; follows RV32M_EN for the multiply path.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] ir;
  logic [2:0]  immSel;
  logic        aluSrcA;
  logic        aluSrcB;
  logic        branchTaken;
  logic        pcWrite;
  logic [1:0]  pcSel;
  logic        dmemReq;
  logic        dmemWe;
  logic        dmemAck;
  logic        mulDivStart;
  logic        mulDivDone;
  logic        regWrite;
  logic [1:0]  wbSel;
  logic        trap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MULDIV_TIMEOUT(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .imemReq     (imemReq),
    .imemAck     (imemAck),
    .imemData    (imemData),
    .ir          (ir),
    .immSel      (immSel),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .branchTaken (branchTaken),
    .pcWrite     (pcWrite),
    .pcSel       (pcSel),
    .dmemReq     (dmemReq),
    .dmemWe      (dmemWe),
    .dmemAck     (dmemAck),
    .mulDivStart (mulDivStart),
    .mulDivDone  (mulDivDone),
    .regWrite    (regWrite),
    .wbSel       (wbSel),
    .trap        (trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in a FETCH cycle; returns one delay into the following DECODE cycle.
  task automatic fetch(input logic [31:0] ins);
    imemData = ins;
    imemAck  = 1'b1;
    #1;
    chk("fetch_req", 32'(imemReq), 32'd1);
    chk("fetch_imm", 32'(immSel), 32'd5);
    step();
    imemAck = 1'b0;
    #1;
    chk("dec_ir", ir, ins);
    chk("dec_req", 32'(imemReq), 32'd0);
  endtask

  initial begin
    rst = 1'b1; imemAck = 1'b0; imemData = 32'h0; branchTaken = 1'b0;
    dmemAck = 1'b0; mulDivDone = 1'b0;
    #2;
    chk("rst_imemReq", 32'(imemReq), 32'd0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_immSel", 32'(immSel), 32'd5);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_strobes", 32'({pcWrite, regWrite, dmemReq, dmemWe, mulDivStart}), 32'd0);
    chk("rst_selects", 32'({pcSel, wbSel, aluSrcA, aluSrcB}), 32'd0);
    step();
    rst = 1'b0;
    #1;

    // ADDI x1,x0,5 with imemAck delayed three cycles
    imemData = 32'h0050_0093;
    for (int i = 0; i < 3; i++) begin
      chk("addi_wait_req", 32'(imemReq), 32'd1);
      step();
    end
    fetch(32'h0050_0093);
    chk("addi_dec_imm", 32'(immSel), 32'd0);
    step();
    chk("addi_ex_srcB", 32'(aluSrcB), 32'd1);
    chk("addi_ex_srcA", 32'(aluSrcA), 32'd0);
    chk("addi_ex_imm", 32'(immSel), 32'd0);
    chk("addi_ex_strobes", 32'({pcWrite, regWrite}), 32'd0);
    step();
    chk("addi_wb_rw", 32'(regWrite), 32'd1);
    chk("addi_wb_sel", 32'(wbSel), 32'd0);
    chk("addi_wb_pc", 32'({pcWrite, pcSel}), 32'b100);
    step();

    // LW x2,8(x1) with dmemAck delayed two cycles
    fetch(32'h0080_A103);
    chk("lw_dec_imm", 32'(immSel), 32'd0);
    step();
    chk("lw_ex_srcB", 32'(aluSrcB), 32'd1);
    chk("lw_ex_dreq", 32'(dmemReq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      dmemAck = (i == 2);
      #1;
      chk("lw_mem_req_we", 32'({dmemReq, dmemWe}), 32'b10);
      chk("lw_mem_pcw", 32'(pcWrite), 32'd0);
    end
    step();
    dmemAck = 1'b0;
    #1;
    chk("lw_wb_sel", 32'(wbSel), 32'd1);
    chk("lw_wb_rw_pcw", 32'({regWrite, pcWrite}), 32'b11);
    step();

    // SW x2,12(x1) with dmemAck delayed two cycles
    fetch(32'h0020_A623);
    chk("sw_dec_imm", 32'(immSel), 32'd1);
    step();
    chk("sw_ex_srcB", 32'(aluSrcB), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      dmemAck = (i == 2);
      #1;
      chk("sw_mem_req_we", 32'({dmemReq, dmemWe}), 32'b11);
      chk("sw_mem_pcw", 32'(pcWrite), (i == 2) ? 32'd1 : 32'd0);
      chk("sw_mem_rw", 32'(regWrite), 32'd0);
    end
    chk("sw_ack_pcsel", 32'(pcSel), 32'd0);
    step();
    dmemAck = 1'b0;
    #1;
    chk("sw_next_fetch", 32'({imemReq, regWrite, dmemReq}), 32'b100);

    // BEQ taken
    fetch(32'h0020_8463);
    chk("beq_dec_imm", 32'(immSel), 32'd2);
    step();
    branchTaken = 1'b1;
    #1;
    chk("beqt_ex_pc", 32'({pcWrite, pcSel}), 32'b101);
    chk("beqt_ex_srcA", 32'(aluSrcA), 32'd1);
    chk("beqt_ex_imm", 32'(immSel), 32'd2);
    step();
    branchTaken = 1'b0;
    #1;
    chk("beqt_no_wb", 32'({imemReq, regWrite}), 32'b10);

    // BEQ not taken, with a stray imemAck in EXEC that must not load ir
    fetch(32'h0020_8463);
    step();
    imemAck  = 1'b1;
    imemData = 32'hFFFF_FFFF;
    #1;
    chk("beqn_ex_pc", 32'({pcWrite, pcSel}), 32'b100);
    step();
    imemAck = 1'b0;
    #1;
    chk("beqn_no_wb", 32'({imemReq, regWrite}), 32'b10);
    chk("stray_ack_ir", ir, 32'h0020_8463);

    // JAL x1,+16
    fetch(32'h0100_00EF);
    chk("jal_dec_imm", 32'(immSel), 32'd3);
    step();
    chk("jal_ex_src", 32'({aluSrcA, aluSrcB}), 32'b11);
    step();
    chk("jal_wb_imm", 32'(immSel), 32'd3);
    chk("jal_wb_sel", 32'(wbSel), 32'd2);
    chk("jal_wb_pc", 32'({pcWrite, pcSel}), 32'b101);
    chk("jal_wb_rw", 32'(regWrite), 32'd1);
    step();

    // JALR x0,0(x1)
    fetch(32'h0000_8067);
    chk("jalr_dec_imm", 32'(immSel), 32'd0);
    step();
    chk("jalr_ex_src", 32'({aluSrcA, aluSrcB}), 32'b01);
    step();
    chk("jalr_wb_pc", 32'({pcWrite, pcSel}), 32'b110);
    chk("jalr_wb_rw", 32'(regWrite), 32'd0);
    chk("jalr_wb_sel", 32'(wbSel), 32'd2);
    step();

    // LUI x5,0x12345
    fetch(32'h1234_52B7);
    chk("lui_dec_imm", 32'(immSel), 32'd4);
    step();
    step();
    chk("lui_wb_sel", 32'(wbSel), 32'd3);
    chk("lui_wb_rw_pc", 32'({regWrite, pcWrite, pcSel}), 32'b1100);
    step();

    // ADD x3,x1,x2
    fetch(32'h0020_81B3);
    chk("add_dec_imm", 32'(immSel), 32'd5);
    step();
    chk("add_ex_src", 32'({aluSrcA, aluSrcB, mulDivStart}), 32'b000);
    step();
    chk("add_wb", 32'({regWrite, wbSel}), 32'b100);
    step();

    // Asynchronous reset in the middle of a MEM cycle, then a pending dmemAck
    fetch(32'h0080_A103);
    step();
    step();
    chk("lwr_mem_req", 32'(dmemReq), 32'd1);
    rst = 1'b1;
    #1;
    chk("lwr_rst_dreq", 32'({dmemReq, imemReq}), 32'b00);
    dmemAck = 1'b1;
    rst     = 1'b0;
    #1;
    chk("lwr_fetch", 32'({imemReq, dmemReq}), 32'b10);
    chk("lwr_ir", ir, 32'h0000_0013);
    step();
    chk("lwr_ack_ignored", 32'({imemReq, dmemReq, regWrite}), 32'b100);
    dmemAck = 1'b0;

    // MUL x3,x1,x2
    fetch(32'h0220_81B3);
    chk("mul_dec_imm", 32'(immSel), 32'd5);
`ifdef RV32M_EN
    step();
    chk("mul_ex_start", 32'(mulDivStart), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      mulDivDone = (i == 9);
      #1;
      chk("mul_wait", 32'({mulDivStart, regWrite, trap}), 32'b000);
    end
    step();
    mulDivDone = 1'b0;
    #1;
    chk("mul_wb", 32'({regWrite, pcWrite, wbSel}), 32'b1100);
    step();
    fetch(32'h0220_81B3);
    step();
    step();
    for (int i = 0; i < 40; i++) begin
      chk("mul_to_wait", 32'({trap, mulDivStart}), 32'b00);
      step();
    end
    chk("mul_timeout_trap", 32'(trap), 32'd1);
`else
    step();
    chk("mul_illegal_trap", 32'(trap), 32'd1);
    chk("mul_illegal_start", 32'(mulDivStart), 32'd0);
`endif
    chk("mul_trap_quiet", 32'({imemReq, immSel}), 32'b0101);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("mul_rst_clear", 32'({trap, imemReq}), 32'b01);

    // Illegal opcode, stray handshakes while trapped, then mid-cycle reset
    fetch(32'h0000_007F);
    chk("ill_dec_imm", 32'(immSel), 32'd5);
    step();
    chk("ill_trap", 32'(trap), 32'd1);
    imemAck    = 1'b1;
    dmemAck    = 1'b1;
    mulDivDone = 1'b1;
    step();
    step();
    chk("ill_trap_held", 32'(trap), 32'd1);
    chk("ill_trap_quiet", 32'({imemReq, dmemReq, pcWrite, regWrite, mulDivStart}), 32'd0);
    chk("ill_trap_ir", ir, 32'h0000_007F);
    rst = 1'b1;
    #1;
    chk("ill_rst_trap", 32'(trap), 32'd0);
    chk("ill_rst_ir", ir, 32'h0000_0013);
    chk("ill_rst_req_imm", 32'({imemReq, immSel}), 32'b0101);
    imemAck    = 1'b0;
    dmemAck    = 1'b0;
    mulDivDone = 1'b0;
    rst        = 1'b0;
    #1;
    chk("ill_post_fetch", 32'({imemReq, trap}), 32'b10);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
